// File: rtl/usb2_ep_ctrl.sv
// usb2_ep_ctrl: per-endpoint buffer/toggle status between the USB 2.0 packet handler and application.
// Optional macro USB2_EP_STATS_EN adds per-endpoint commit+arm counters on app_stat_cnt.
module usb2_ep_ctrl #(
  parameter int          NUM_EP   = 4,
  parameter logic [31:0] EP_MODES = 32'h000000A8,
  parameter int          MAX_PKT  = 512
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic [3:0]  sel_endp,
  input  logic        buf_in_commit,
  input  logic [10:0] buf_in_commit_len,
  output logic        buf_in_commit_ack,
  output logic        buf_in_ready,
  input  logic        buf_out_arm,
  output logic        buf_out_arm_ack,
  output logic        buf_out_hasdata,
  output logic [10:0] buf_out_len,
  output logic [1:0]  endp_mode,
  input  logic        data_toggle_act,
  output logic [1:0]  data_toggle,
  input  logic [3:0]  app_ep,
  input  logic [1:0]  app_op,
  input  logic [10:0] app_len,
  input  logic        app_req,
  output logic        app_ack,
  output logic        app_rx_full,
  output logic [10:0] app_rx_len,
  output logic        err_overrun,
  output logic        err_bad_ep
`ifdef USB2_EP_STATS_EN
  ,
  output logic [15:0] app_stat_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, EXEC, ACK} app_st_e;
  localparam logic [4:0]  NEP  = 5'(NUM_EP);
  localparam logic [10:0] MAXL = 11'(MAX_PKT);
  // State is held for all 16 addresses; entries >= NUM_EP are never written and stay zero.
  logic [15:0] rx_full_q, rx_full_d, tx_loaded_q, tx_loaded_d, tog_q, tog_d;
  logic [10:0] rx_len_q [16];
  logic [10:0] rx_len_d [16];
  logic [10:0] tx_len_q [16];
  logic [10:0] tx_len_d [16];
  app_st_e     st_q, st_d;
  logic        ovr_q, ovr_d, bad_q, bad_d;
  logic        cack_q, aack_q, ready_q, hasdata_q, arx_full_q;
  logic [10:0] olen_q, arx_len_q;
  logic [1:0]  mode_q, tog_out_q;
  logic        sel_ok, app_ok, conflict;
`ifdef USB2_EP_STATS_EN
  logic [15:0] cnt_q [16];
  logic [15:0] cnt_d [16];
  logic [15:0] stat_q;
`endif

  function automatic logic [1:0] mode_of(input logic [3:0] e);
    return (e == 4'd0) ? 2'b00 : ({1'b0, e} >= NEP) ? 2'b10 : EP_MODES[{e, 1'b0} +: 2];
  endfunction

  assign sel_ok   = {1'b0, sel_endp} < NEP;
  assign app_ok   = {1'b0, app_ep} < NEP;
  assign conflict = sel_ok && (sel_endp == app_ep) && (buf_in_commit || buf_out_arm || data_toggle_act);

  always_comb begin
    rx_full_d   = rx_full_q;
    tx_loaded_d = tx_loaded_q;
    tog_d       = tog_q;
    rx_len_d    = rx_len_q;
    tx_len_d    = tx_len_q;
    st_d        = st_q;
    ovr_d       = ovr_q;
    bad_d       = bad_q | (!sel_ok && (buf_in_commit || buf_out_arm || data_toggle_act));
`ifdef USB2_EP_STATS_EN
    cnt_d = cnt_q;
    if (sel_ok)
      cnt_d[sel_endp] = cnt_q[sel_endp] + 16'(buf_in_commit) + 16'(buf_out_arm);
`endif
    if (sel_ok && buf_in_commit) begin
      ovr_d = ovr_q | rx_full_q[sel_endp];
      rx_full_d[sel_endp] = 1'b1;
      rx_len_d[sel_endp]  = buf_in_commit_len;
    end
    if (sel_ok && buf_out_arm)
      tx_loaded_d[sel_endp] = 1'b0;
    if (sel_ok && data_toggle_act)
      tog_d[sel_endp] = (mode_of(sel_endp) == 2'b01) ? 1'b0 : ~tog_q[sel_endp];
    case (st_q)
      IDLE: st_d = app_req ? EXEC : IDLE;
      EXEC: if (!conflict) begin
        st_d = ACK;
        if (!app_ok) bad_d = 1'b1;
        else case (app_op)
          2'd1: rx_full_d[app_ep] = 1'b0;
          2'd2: begin
            tx_loaded_d[app_ep] = 1'b1;
            tx_len_d[app_ep]    = (app_len > MAXL) ? MAXL : app_len;
          end
          2'd3: tog_d[app_ep] = 1'b0;
          default: ;
        endcase
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      st_q        <= IDLE;
      rx_full_q   <= '0;
      tx_loaded_q <= '0;
      tog_q       <= '0;
      rx_len_q    <= '{default: '0};
      tx_len_q    <= '{default: '0};
      ovr_q       <= 1'b0;
      bad_q       <= 1'b0;
      cack_q      <= 1'b0;
      aack_q      <= 1'b0;
      ready_q     <= 1'b0;
      hasdata_q   <= 1'b0;
      olen_q      <= '0;
      mode_q      <= '0;
      tog_out_q   <= '0;
      arx_full_q  <= 1'b0;
      arx_len_q   <= '0;
`ifdef USB2_EP_STATS_EN
      cnt_q       <= '{default: '0};
      stat_q      <= '0;
`endif
    end else begin
      st_q        <= st_d;
      rx_full_q   <= rx_full_d;
      tx_loaded_q <= tx_loaded_d;
      tog_q       <= tog_d;
      rx_len_q    <= rx_len_d;
      tx_len_q    <= tx_len_d;
      ovr_q       <= ovr_d;
      bad_q       <= bad_d;
      cack_q      <= sel_ok & buf_in_commit;
      aack_q      <= sel_ok & buf_out_arm;
      ready_q     <= sel_ok & ~rx_full_d[sel_endp];
      hasdata_q   <= sel_ok & tx_loaded_d[sel_endp];
      olen_q      <= sel_ok ? tx_len_d[sel_endp] : 11'd0;
      mode_q      <= mode_of(sel_endp);
      tog_out_q   <= {1'b0, sel_ok & tog_d[sel_endp]};
      arx_full_q  <= app_ok & rx_full_d[app_ep];
      arx_len_q   <= app_ok ? rx_len_d[app_ep] : 11'd0;
`ifdef USB2_EP_STATS_EN
      cnt_q       <= cnt_d;
      stat_q      <= app_ok ? cnt_d[app_ep] : 16'd0;
`endif
    end
  end

  assign buf_in_commit_ack = cack_q;
  assign buf_out_arm_ack   = aack_q;
  assign buf_in_ready      = ready_q;
  assign buf_out_hasdata   = hasdata_q;
  assign buf_out_len       = olen_q;
  assign endp_mode         = mode_q;
  assign data_toggle       = tog_out_q;
  assign app_ack           = (st_q == ACK);
  assign app_rx_full       = arx_full_q;
  assign app_rx_len        = arx_len_q;
  assign err_overrun       = ovr_q;
  assign err_bad_ep        = bad_q;
`ifdef USB2_EP_STATS_EN
  assign app_stat_cnt      = stat_q;
`endif
endmodule

// File: tb/tb_usb2_ep_ctrl.sv
// tb_usb2_ep_ctrl: directed and randomized checks of usb2_ep_ctrl against an endpoint-table model.
module tb_usb2_ep_ctrl;
  logic        phy_clk = 1'b0, reset = 1'b1;
  logic [3:0]  sel_endp = '0, app_ep = '0;
  logic        buf_in_commit = 1'b0, buf_out_arm = 1'b0, data_toggle_act = 1'b0, app_req = 1'b0;
  logic [10:0] buf_in_commit_len = '0, app_len = '0;
  logic [1:0]  app_op = '0;
  logic        buf_in_commit_ack, buf_in_ready, buf_out_arm_ack, buf_out_hasdata, app_ack;
  logic        app_rx_full, err_overrun, err_bad_ep;
  logic [10:0] buf_out_len, app_rx_len;
  logic [1:0]  endp_mode, data_toggle;

  always #5 phy_clk = ~phy_clk;

  usb2_ep_ctrl #(.NUM_EP(4), .EP_MODES(32'h00000068), .MAX_PKT(512)) dut (
    .phy_clk(phy_clk), .reset(reset), .sel_endp(sel_endp),
    .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
    .buf_in_commit_ack(buf_in_commit_ack), .buf_in_ready(buf_in_ready),
    .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
    .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len), .endp_mode(endp_mode),
    .data_toggle_act(data_toggle_act), .data_toggle(data_toggle),
    .app_ep(app_ep), .app_op(app_op), .app_len(app_len), .app_req(app_req), .app_ack(app_ack),
    .app_rx_full(app_rx_full), .app_rx_len(app_rx_len),
    .err_overrun(err_overrun), .err_bad_ep(err_bad_ep)
  );

  int npass = 0, ntot = 0;
  bit m_full[16], m_load[16], m_tog[16], m_ovr, m_bad;
  int m_rlen[16], m_tlen[16];
  int m_mode[4] = '{0, 2, 2, 1};

  function automatic int e_mode(int s);
    return (s < 4) ? m_mode[s] : 2;
  endfunction

  task automatic tick;
    @(negedge phy_clk);
  endtask

  task automatic model_reset;
    for (int i = 0; i < 16; i++) begin
      m_full[i] = 0; m_load[i] = 0; m_tog[i] = 0; m_rlen[i] = 0; m_tlen[i] = 0;
    end
    m_ovr = 0; m_bad = 0;
  endtask

  task automatic proto(input int s, input bit c, input bit a, input bit t, input int len);
    sel_endp = 4'(s); buf_in_commit = c; buf_out_arm = a; data_toggle_act = t;
    buf_in_commit_len = 11'(len);
    tick;
    buf_in_commit = 0; buf_out_arm = 0; data_toggle_act = 0;
    if (s >= 4) begin
      if (c || a || t) m_bad = 1;
    end else begin
      if (c) begin
        if (m_full[s]) m_ovr = 1;
        m_full[s] = 1; m_rlen[s] = len;
      end
      if (a) m_load[s] = 0;
      if (t && m_mode[s] != 1) m_tog[s] = !m_tog[s];
    end
  endtask

  task automatic do_app(input int ep, input int op, input int len, output int lat);
    app_ep = 4'(ep); app_op = 2'(op); app_len = 11'(len); app_req = 1; lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (app_ack) begin lat = i; break; end
    end
    app_req = 0;
    if (ep >= 4) m_bad = 1;
    else case (op)
      1: m_full[ep] = 0;
      2: begin m_load[ep] = 1; m_tlen[ep] = (len > 512) ? 512 : len; end
      3: m_tog[ep] = 0;
      default: ;
    endcase
    tick;
  endtask

  task automatic test_reset;
    reset = 1; tick; tick;
    ntot++;
    if ({buf_in_ready, buf_out_hasdata, buf_out_len, endp_mode, data_toggle, buf_in_commit_ack,
         buf_out_arm_ack, app_ack, app_rx_full, app_rx_len, err_overrun, err_bad_ep} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs ready=%b has=%b len=%0d mode=%0d", buf_in_ready,
               buf_out_hasdata, buf_out_len, endp_mode);
    else npass++;
    reset = 0; model_reset; sel_endp = 1; tick;
    ntot++;
    if ({buf_in_ready, buf_out_hasdata, endp_mode, data_toggle} !== {1'b1, 1'b0, 2'd2, 2'd0})
      $display("FAIL sel_ep1: got ready=%b has=%b mode=%0d tog=%0d, want 1 0 2 0", buf_in_ready,
               buf_out_hasdata, endp_mode, data_toggle);
    else npass++;
  endtask

  task automatic test_commit;
    app_ep = 1;
    proto(1, 1, 0, 0, 64);
    ntot++;
    if ({buf_in_commit_ack, buf_in_ready, app_rx_full, app_rx_len} !== {1'b1, 1'b0, 1'b1, 11'd64})
      $display("FAIL commit: got ack=%b ready=%b full=%b len=%0d, want 1 0 1 64", buf_in_commit_ack,
               buf_in_ready, app_rx_full, app_rx_len);
    else npass++;
    tick;
    ntot++;
    if (buf_in_commit_ack !== 1'b0) $display("FAIL commit_ack_pulse: got %b want 0", buf_in_commit_ack);
    else npass++;
  endtask

  task automatic test_load_arm;
    int lat;
    do_app(2, 2, 700, lat);
    ntot++;
    if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else npass++;
    sel_endp = 2; tick;
    ntot++;
    if ({buf_out_hasdata, buf_out_len} !== {1'b1, 11'd512})
      $display("FAIL load_clamp: got has=%b len=%0d, want 1 512", buf_out_hasdata, buf_out_len);
    else npass++;
    proto(2, 0, 1, 0, 0);
    ntot++;
    if ({buf_out_arm_ack, buf_out_hasdata} !== 2'b10)
      $display("FAIL arm: got ack=%b has=%b, want 1 0", buf_out_arm_ack, buf_out_hasdata);
    else npass++;
  endtask

  task automatic test_toggle;
    int lat;
    logic [1:0] want[3] = '{2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 3; i++) begin
      proto(1, 0, 0, 1, 0);
      ntot++;
      if (data_toggle !== want[i]) $display("FAIL toggle_bulk_%0d: got %0d want %0d", i, data_toggle, want[i]);
      else npass++;
    end
    proto(3, 0, 0, 1, 0);
    ntot++;
    if ({endp_mode, data_toggle} !== {2'd1, 2'd0})
      $display("FAIL toggle_isoch: got mode=%0d tog=%0d want 1 0", endp_mode, data_toggle);
    else npass++;
    do_app(1, 3, 0, lat);
    sel_endp = 1; tick;
    ntot++;
    if (data_toggle !== 2'd0) $display("FAIL clear_toggle: got %0d want 0", data_toggle); else npass++;
  endtask

  task automatic test_overrun;
    int lat;
    app_ep = 1;
    proto(1, 1, 0, 0, 100);
    ntot++;
    if ({err_overrun, app_rx_len} !== {1'b1, 11'd100})
      $display("FAIL overrun: got err=%b len=%0d want 1 100", err_overrun, app_rx_len);
    else npass++;
    do_app(1, 1, 0, lat);
    sel_endp = 1; tick;
    ntot++;
    if (buf_in_ready !== 1'b1) $display("FAIL release: got ready=%b want 1", buf_in_ready); else npass++;
  endtask

  task automatic test_stall;
    app_ep = 1; app_op = 1; app_req = 1;
    tick;
    sel_endp = 1; buf_in_commit = 1; buf_in_commit_len = 11'd33;
    tick;
    buf_in_commit = 0; m_full[1] = 1; m_rlen[1] = 33;
    ntot++;
    if ({app_ack, buf_in_commit_ack} !== 2'b01)
      $display("FAIL stall_cycle: got app_ack=%b commit_ack=%b want 0 1", app_ack, buf_in_commit_ack);
    else npass++;
    tick;
    m_full[1] = 0;
    ntot++;
    if ({app_ack, buf_in_ready, app_rx_full} !== 3'b110)
      $display("FAIL stall_ack: got ack=%b ready=%b full=%b want 1 1 0", app_ack, buf_in_ready, app_rx_full);
    else npass++;
    app_req = 0; tick;
    ntot++;
    if (app_ack !== 1'b0) $display("FAIL stall_ack_pulse: got %b want 0", app_ack); else npass++;
  endtask

  task automatic test_bad_ep;
    proto(7, 1, 0, 0, 10);
    ntot++;
    if ({buf_in_commit_ack, err_bad_ep, buf_in_ready, endp_mode, buf_out_len} !== {1'b0, 1'b1, 1'b0, 2'd2, 11'd0})
      $display("FAIL bad_ep: got ack=%b err=%b ready=%b mode=%0d len=%0d want 0 1 0 2 0", buf_in_commit_ack,
               err_bad_ep, buf_in_ready, endp_mode, buf_out_len);
    else npass++;
  endtask

  task automatic test_random;
    int lat, s, ae;
    bit c, a, t;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        ae = $urandom_range(0, 4);
        do_app(ae, $urandom_range(0, 3), $urandom_range(0, 2047), lat);
        ntot++;
        if (lat !== 2) $display("FAIL rnd_app_latency[%0d]: got %0d want 2", n, lat); else npass++;
      end
      s = $urandom_range(0, 5); ae = $urandom_range(0, 4);
      c = $urandom_range(0, 1); a = $urandom_range(0, 1); t = $urandom_range(0, 1);
      app_ep = 4'(ae);
      proto(s, c, a, t, $urandom_range(0, 2047));
      ntot++;
      if ({buf_in_commit_ack, buf_out_arm_ack} !== {c && s < 4, a && s < 4})
        $display("FAIL rnd_acks[%0d]: got %b%b want %b%b", n, buf_in_commit_ack, buf_out_arm_ack, c && s < 4, a && s < 4);
      else npass++;
      ntot++;
      if ({buf_in_ready, buf_out_hasdata, buf_out_len, endp_mode, data_toggle} !==
          {s < 4 && !m_full[s], s < 4 && m_load[s], 11'(s < 4 ? m_tlen[s] : 0), 2'(e_mode(s)),
           2'(s < 4 && m_tog[s])})
        $display("FAIL rnd_sel[%0d] ep%0d: got rdy=%b has=%b len=%0d mode=%0d tog=%0d want %b %b %0d %0d %0d",
                 n, s, buf_in_ready, buf_out_hasdata, buf_out_len, endp_mode, data_toggle, s < 4 && !m_full[s],
                 s < 4 && m_load[s], s < 4 ? m_tlen[s] : 0, e_mode(s), s < 4 && m_tog[s]);
      else npass++;
      ntot++;
      if ({app_rx_full, app_rx_len, err_overrun, err_bad_ep} !==
          {ae < 4 && m_full[ae], 11'(ae < 4 ? m_rlen[ae] : 0), m_ovr, m_bad})
        $display("FAIL rnd_app[%0d] ep%0d: got full=%b len=%0d ovr=%b bad=%b want %b %0d %b %b", n, ae,
                 app_rx_full, app_rx_len, err_overrun, err_bad_ep, ae < 4 && m_full[ae],
                 ae < 4 ? m_rlen[ae] : 0, m_ovr, m_bad);
      else npass++;
    end
  endtask

  task automatic test_reset_mid;
    app_ep = 1; app_op = 1; app_req = 1;
    tick;
    reset = 1; tick;
    app_req = 0; reset = 0; model_reset;
    ntot++;
    if ({app_ack, app_rx_full, buf_out_hasdata, err_overrun, err_bad_ep} !== '0)
      $display("FAIL reset_mid: got ack=%b full=%b has=%b ovr=%b bad=%b want 0", app_ack, app_rx_full,
               buf_out_hasdata, err_overrun, err_bad_ep);
    else npass++;
    for (int i = 0; i < 3; i++) begin
      tick;
      ntot++;
      if (app_ack !== 1'b0) $display("FAIL reset_mid_noack_%0d: got %b want 0", i, app_ack); else npass++;
    end
    sel_endp = 2; tick;
    ntot++;
    if ({buf_in_ready, buf_out_hasdata, buf_out_len} !== {1'b1, 1'b0, 11'd0})
      $display("FAIL reset_mid_state: got rdy=%b has=%b len=%0d want 1 0 0", buf_in_ready, buf_out_hasdata, buf_out_len);
    else npass++;
  endtask

  initial begin
    model_reset;
    test_reset;
    test_commit;
    test_load_arm;
    test_toggle;
    test_overrun;
    test_stall;
    test_bad_ep;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
